// File: rtl/lc3_mem_pkg.sv
// Shared types and memory-mapped I/O addresses for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port word RAM with registered read; read-before-write on the same address.
module lc3_mem_array #(
  parameter int unsigned MEM_AW    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// CPU-side memory responder: latency-programmable RAM access plus KBSR/KBDR/DSR/DDR devices.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned LATENCY   = 3,
  parameter string       INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DataIn,
  output logic [15:0] out,
  output logic        ready,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  mem_state_t  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;
  logic [15:0] req_addr, req_data;
  logic        req_we;
  logic        kbsr_full, dsr_rdy;
  logic [7:0]  kbdr;
  logic [15:0] ram_rdata, rd_data;
  logic [MEM_AW-1:0] ram_addr;
  logic        ram_we, in_ram;
  logic        is_kbsr, is_kbdr, is_dsr, is_ddr, resp_rd, resp_wr;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: if (CS) begin
        accept   = 1'b1;
        cnt_nx   = CNT_LOAD;
        state_nx = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: if (cnt == '0) state_nx = RESP;
            else           cnt_nx   = cnt - 4'd1;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign is_kbsr = (req_addr == ADDR_KBSR);
  assign is_kbdr = (req_addr == ADDR_KBDR);
  assign is_dsr  = (req_addr == ADDR_DSR);
  assign is_ddr  = (req_addr == ADDR_DDR);
  assign in_ram  = (32'(req_addr) < (32'd1 << MEM_AW));
  assign ready   = (state == RESP);
  assign resp_rd = ready && !req_we;
  assign resp_wr = ready && req_we;

  // In IDLE the RAM sees the live bus so a LATENCY==1 read is issued on the acceptance edge.
  assign ram_addr = (state == IDLE) ? ADDR[MEM_AW-1:0] : req_addr[MEM_AW-1:0];
  assign ram_we   = resp_wr && in_ram && !is_kbsr && !is_kbdr && !is_dsr && !is_ddr && !RST;

  lc3_mem_array #(.MEM_AW(MEM_AW), .INIT_FILE(INIT_FILE)) u_array (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_data = '0;
    if      (is_kbsr) rd_data = {kbsr_full, 15'b0};
    else if (is_kbdr) rd_data = {8'b0, kbdr};
    else if (is_dsr)  rd_data = {dsr_rdy, 15'b0};
    else if (is_ddr)  rd_data = '0;
    else if (in_ram)  rd_data = ram_rdata;
  end

  assign out       = resp_rd ? rd_data : '0;
  assign kbd_ready = !kbsr_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_we     <= 1'b0;
      kbsr_full  <= 1'b0;
      kbdr       <= '0;
      dsr_rdy    <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        req_addr <= ADDR;
        req_data <= DataIn;
        req_we   <= WE;
      end
      // A KBDR read wins over a same-cycle offer; the full flag blocks the offer anyway.
      if (resp_rd && is_kbdr) begin
        kbsr_full <= 1'b0;
      end else if (kbd_valid && !kbsr_full) begin
        kbsr_full <= 1'b1;
        kbdr      <= kbd_data;
      end
      if (resp_wr && is_ddr && dsr_rdy) begin
        disp_data  <= req_data[7:0];
        disp_valid <= 1'b1;
        dsr_rdy    <= 1'b0;
      end else if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
        dsr_rdy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder against a behavioural memory/device model.
module tb_lc3_mem_responder;

  localparam int unsigned LAT       = 3;
  localparam int          RAM_WORDS = 4096;

  logic        CLK = 1'b0, RST = 1'b1, CS = 1'b0, WE = 1'b0;
  logic [15:0] ADDR = '0, DataIn = '0, out;
  logic        ready, kbd_valid = 1'b0, kbd_ready, disp_valid, disp_ready = 1'b0;
  logic [7:0]  kbd_data = '0, disp_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [int];
  bit          kb_full;
  logic [7:0]  kb_char;
  bit          ds_rdy;
  bit          dp_valid;
  logic [7:0]  dp_data;

  lc3_mem_responder #(.MEM_AW(12), .LATENCY(LAT), .INIT_FILE("")) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
    .out(out), .ready(ready), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .kbd_ready(kbd_ready), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ready(disp_ready)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    kb_full = 0; kb_char = '0; ds_rdy = 1; dp_valid = 0; dp_data = '0;
  endfunction

  function automatic logic [15:0] model_read(logic [15:0] a);
    case (a)
      16'hFE00: return {kb_full, 15'b0};
      16'hFE02: return {8'h00, kb_char};
      16'hFE04: return {ds_rdy, 15'b0};
      16'hFE06: return 16'h0000;
      default:  return (int'(a) < RAM_WORDS && mem_m.exists(int'(a))) ? mem_m[int'(a)] : 16'h0000;
    endcase
  endfunction

  function automatic void model_commit(logic we, logic [15:0] a, logic [15:0] d);
    if (we) begin
      if (a == 16'hFE06) begin
        if (ds_rdy) begin dp_valid = 1; dp_data = d[7:0]; ds_rdy = 0; end
      end else if (int'(a) < RAM_WORDS) mem_m[int'(a)] = d;
    end else if (a == 16'hFE02) kb_full = 0;
  endfunction

  // One access: request held only for the acceptance edge, bus scrambled afterwards.
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd);
    int lat = 0;
    bit seen = 0;
    CS = 1'b1; WE = we; ADDR = a; DataIn = d;
    @(posedge CLK); #1;
    CS = 1'b0; WE = 1'($urandom); ADDR = 16'($urandom); DataIn = 16'($urandom);
    while (!seen && lat < 40) begin
      @(negedge CLK);
      if (ready) seen = 1;
      else begin
        checks++;
        if (out !== 16'h0000) begin
          errors++; $display("FAIL out_idle addr=%h got=%h exp=0000", a, out);
        end
        lat++;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ready_timeout addr=%h waited=%0d cycles", a, lat);
    end else if (lat != int'(LAT)) begin
      errors++; $display("FAIL latency addr=%h got=%0d exp=%0d", a, lat, LAT);
    end
    rd = out;
    model_commit(we, a, d);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL ready_width addr=%h got=%b exp=0", a, ready);
    end
  endtask

  task automatic offer_kbd(input logic [7:0] ch);
    checks++;
    if (kbd_ready !== !kb_full) begin
      errors++; $display("FAIL kbd_ready got=%b exp=%b", kbd_ready, !kb_full);
    end
    kbd_valid = 1'b1; kbd_data = ch;
    @(posedge CLK); #1;
    kbd_valid = 1'b0; kbd_data = 8'($urandom);
    if (!kb_full) begin kb_full = 1; kb_char = ch; end
    @(negedge CLK);
  endtask

  task automatic drain_disp();
    disp_ready = 1'b1;
    @(posedge CLK); #1;
    disp_ready = 1'b0;
    if (dp_valid) begin dp_valid = 0; ds_rdy = 1; end
    @(negedge CLK);
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL disp_drain got=%b exp=0", disp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks += 5;
    if (ready !== 1'b0)      begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
    if (out !== 16'h0000)    begin errors++; $display("FAIL rst_out got=%h exp=0000", out); end
    if (kbd_ready !== 1'b1)  begin errors++; $display("FAIL rst_kbd_ready got=%b exp=1", kbd_ready); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got=%b exp=0", disp_valid); end
    if (disp_data !== 8'h00) begin errors++; $display("FAIL rst_disp_data got=%h exp=00", disp_data); end
  endtask

  task automatic test_ram_rw();
    logic [15:0] rd, exp;
    logic [15:0] addrs[$];
    access(1'b1, 16'h0010, 16'h1234, rd);
    access(1'b0, 16'h0010, 16'h0000, rd);
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL ram_basic got=%h exp=1234", rd); end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(RAM_WORDS - 1));
      addrs.push_back(a);
      access(1'b1, a, 16'($urandom), rd);
    end
    addrs.shuffle();
    foreach (addrs[i]) begin
      exp = model_read(addrs[i]);
      access(1'b0, addrs[i], 16'($urandom), rd);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL ram_rand addr=%h got=%h exp=%h", addrs[i], rd, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, e0, e1;
    int n = 0;
    int gap = 0;
    access(1'b1, 16'h0010, 16'($urandom), rd);
    access(1'b1, 16'h0011, 16'($urandom), rd);
    e0 = model_read(16'h0010);
    e1 = model_read(16'h0011);
    CS = 1'b1; WE = 1'b0; ADDR = 16'h0010;
    while (!ready && n < 40) begin @(negedge CLK); n++; end
    checks++;
    if (!ready || out !== e0) begin errors++; $display("FAIL b2b_first ready=%b got=%h exp=%h", ready, out, e0); end
    ADDR = 16'h0011;
    @(posedge CLK); #1;
    do begin @(negedge CLK); gap++; end while (!ready && gap < 40);
    checks += 2;
    if (gap != int'(LAT) + 2) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, LAT + 2); end
    if (out !== e1) begin errors++; $display("FAIL b2b_second got=%h exp=%h", out, e1); end
    CS = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_end ready=%b exp=0", ready); end
  endtask

  task automatic test_keyboard();
    logic [15:0] rd, exp;
    offer_kbd(8'h41);
    offer_kbd(8'h42);
    exp = model_read(16'hFE00);
    access(1'b0, 16'hFE00, '0, rd);
    checks++;
    if (rd !== 16'h8000 || rd !== exp) begin errors++; $display("FAIL kbsr_full got=%h exp=8000", rd); end
    access(1'b0, 16'hFE02, '0, rd);
    checks++;
    if (rd !== 16'h0041) begin errors++; $display("FAIL kbdr_first got=%h exp=0041", rd); end
    access(1'b0, 16'hFE00, '0, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL kbsr_empty got=%h exp=0000", rd); end
    access(1'b1, 16'hFE02, 16'hFFFF, rd);
    offer_kbd(8'h42);
    access(1'b0, 16'hFE02, '0, rd);
    checks++;
    if (rd !== 16'h0042) begin errors++; $display("FAIL kbdr_second got=%h exp=0042", rd); end
    for (int i = 0; i < 4; i++) begin
      offer_kbd(8'($urandom));
      exp = model_read(16'hFE02);
      access(1'b0, 16'hFE02, '0, rd);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL kbdr_rand got=%h exp=%h", rd, exp); end
    end
  endtask

  task automatic test_display();
    logic [15:0] rd, d;
    access(1'b1, 16'hFE06, 16'hAB48, rd);
    checks += 2;
    if (disp_valid !== 1'b1) begin errors++; $display("FAIL ddr_valid got=%b exp=1", disp_valid); end
    if (disp_data !== 8'h48) begin errors++; $display("FAIL ddr_data got=%h exp=48", disp_data); end
    access(1'b0, 16'hFE04, '0, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL dsr_busy got=%h exp=0000", rd); end
    access(1'b1, 16'hFE06, 16'h0055, rd);
    checks++;
    if (disp_data !== dp_data) begin errors++; $display("FAIL ddr_drop got=%h exp=%h", disp_data, dp_data); end
    access(1'b0, 16'hFE06, '0, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL ddr_read got=%h exp=0000", rd); end
    drain_disp();
    access(1'b0, 16'hFE04, '0, rd);
    checks++;
    if (rd !== 16'h8000) begin errors++; $display("FAIL dsr_ready got=%h exp=8000", rd); end
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      access(1'b1, 16'hFE06, d, rd);
      checks++;
      if (disp_valid !== dp_valid || disp_data !== dp_data) begin
        errors++; $display("FAIL ddr_rand got=%b/%h exp=%b/%h", disp_valid, disp_data, dp_valid, dp_data);
      end
      drain_disp();
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd, v0, a;
    access(1'b0, 16'hC000, '0, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL oor_read got=%h exp=0000", rd); end
    v0 = 16'($urandom);
    access(1'b1, 16'h0000, v0, rd);
    access(1'b1, 16'hC000, ~v0, rd);
    access(1'b0, 16'h0000, '0, rd);
    checks++;
    if (rd !== v0) begin errors++; $display("FAIL oor_alias got=%h exp=%h", rd, v0); end
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(16'hFDFF, RAM_WORDS));
      access(1'b1, a, 16'($urandom), rd);
      access(1'b0, a, '0, rd);
      checks++;
      if (rd !== model_read(a)) begin errors++; $display("FAIL oor_rand addr=%h got=%h exp=0000", a, rd); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rd, old;
    int pulses = 0;
    old = 16'($urandom);
    access(1'b1, 16'h0020, old, rd);
    access(1'b1, 16'hFE06, 16'h0021, rd);
    offer_kbd(8'h33);
    CS = 1'b1; WE = 1'b1; ADDR = 16'h0020; DataIn = ~old;
    @(posedge CLK); #1;
    CS = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ready) pulses++;
    end
    checks += 3;
    if (pulses != 0) begin errors++; $display("FAIL rst_mid_ready got=%0d pulses exp=0", pulses); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_disp got=%b exp=0", disp_valid); end
    if (kbd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_kbd got=%b exp=1", kbd_ready); end
    access(1'b0, 16'hFE04, '0, rd);
    checks++;
    if (rd !== 16'h8000) begin errors++; $display("FAIL rst_mid_dsr got=%h exp=8000", rd); end
    access(1'b0, 16'h0020, '0, rd);
    checks++;
    if (rd !== old) begin errors++; $display("FAIL rst_mid_mem got=%h exp=%h", rd, old); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_keyboard();
    test_display();
    test_out_of_range();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
